f_truth_scanner: RTL

Sequential stimulus and capture stage placed directly upstream of the 4-input combinational function `f` (s = ~a·~b + b·~c·d + ~b·~c·~d). On a start request it drives every input vector abcd = 0..15 into `f` and samples the returned `s` for each vector. It assembles a 16-bit truth-table word, compares it bit-by-bit against a parameterised expected table, and reports pass/fail, the mismatch count and the first failing vector. It replaces the hand-written `#1` stimulus lists with a reusable, clocked self-check.

---
 rtl/f_truth_scanner.sv | 119 +++++++++++
 1 files changed

// File: rtl/f_truth_scanner.sv
// rtl/f_truth_scanner.sv - exhaustive stimulus/capture self-check for the 4-input function f
module f_truth_scanner #(
    parameter logic [15:0] EXPECTED = 16'h212F,
    parameter int unsigned SETTLE   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_count,
    output logic        fail_valid,
    output logic [3:0]  first_fail,
    output logic        pass
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic       sample;
    logic       miss;
    logic       last_vec;

    // idx is held at 0 outside DRIVE, so it doubles as the registered stimulus
    assign {a, b, c, d} = idx;

    assign sample   = (state == DRIVE) && (settle_cnt == 4'd0);
    assign miss     = sample && (s_in != EXPECTED[idx]);
    assign last_vec = (idx == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DRIVE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx            <= 4'd0;
            settle_cnt     <= 4'd0;
            table_out      <= 16'h0000;
            mismatch_count <= 5'd0;
            fail_valid     <= 1'b0;
            first_fail     <= 4'd0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx            <= 4'd0;
                        settle_cnt     <= SETTLE_LOAD;
                        table_out      <= 16'h0000;
                        mismatch_count <= 5'd0;
                        fail_valid     <= 1'b0;
                        first_fail     <= 4'd0;
                        pass           <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        table_out[idx] <= s_in;
                        if (miss) begin
                            mismatch_count <= mismatch_count + 5'd1;
                            if (!fail_valid) begin
                                first_fail <= idx;
                                fail_valid <= 1'b1;
                            end
                        end
                        // pass is resolved here, folding in the final sample, so it is already valid during DONE
                        if (last_vec) begin
                            idx  <= 4'd0;
                            pass <= (mismatch_count == 5'd0) && !miss;
                        end else begin
                            idx        <= idx + 4'd1;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
